pipeline_hazard_controller: RTL

Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards, taken branches, multi-cycle EX operations and memory wait.
- Drives the per-stage stall inputs of the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and the bubble-insert (flush) controls.
- Holds a small FSM with a latency counter for multi-cycle EX ops.

---
 rtl/pipeline_ctrl_defs.sv | 35 +++
 rtl/mc_latency_counter.sv | 27 ++
 rtl/pipeline_hazard_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_defs.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM encodings, control bundle and NOP constants used by the pipeline registers.
package pipeline_ctrl_defs;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } hz_state_t;

    // Canonical NOP (addi x0, x0, 0) loaded by a flushed pipeline register
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  NOP_RD    = 5'd0;
    localparam logic        NOP_VALID = 1'b0;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic mem_wb_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } hz_ctrl_t;

    function automatic logic reg_match(
        input logic       used,
        input logic [7:0] src,
        input logic [7:0] dst
    );
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/mc_latency_counter.sv
// Down-counter tracking remaining EX occupancy of a multi-cycle op.
// Load has priority over decrement; neither asserted freezes the count.
module mc_latency_counter #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_val,
    input  logic                dec,
    output logic [CNT_BITS-1:0] cnt,
    output logic                zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_events counters.
module pipeline_hazard_controller
    import pipeline_ctrl_defs::*;
#(
    parameter int REG_ADDR_BITS = 3,
    parameter int MC_LATENCY    = 4,
    parameter int CNT_BITS      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_BITS-1:0] id_rs1,
    input  logic [REG_ADDR_BITS-1:0] id_rs2,
    input  logic                     id_rs1_used,
    input  logic                     id_rs2_used,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    input  logic                     ex_mem_read,
    input  logic                     ex_branch_taken,
    input  logic                     ex_mc_start,
    input  logic                     mem_wait,
    output logic                     pc_stall,
    output logic                     if_id_stall,
    output logic                     id_ex_stall,
    output logic                     ex_mem_stall,
    output logic                     mem_wb_stall,
    output logic                     if_id_flush,
    output logic                     id_ex_flush,
    output logic                     ex_mem_flush,
    output logic                     mem_wb_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0]              stall_cycles,
    output logic [15:0]              flush_events,
`endif
    output logic                     mc_done
);

    localparam logic [CNT_BITS-1:0] MC_LOAD = CNT_BITS'(MC_LATENCY - 2);

    hz_state_t           state_q;
    hz_state_t           state_d;
    hz_ctrl_t            ctrl;
    logic                done_c;
    logic                br_honoured;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic [CNT_BITS-1:0] mc_cnt;
    logic                load_use;
    logic                mc_hold;
    logic [7:0]          rs1_w;
    logic [7:0]          rs2_w;
    logic [7:0]          rd_w;

    assign rs1_w = 8'(id_rs1);
    assign rs2_w = 8'(id_rs2);
    assign rd_w  = 8'(ex_rd);

    assign load_use = ex_mem_read &&
                      (reg_match(id_rs1_used, rs1_w, rd_w) ||
                       reg_match(id_rs2_used, rs2_w, rd_w));

    assign mc_hold = ((state_q == ST_RUN) && ex_mc_start) ||
                     ((state_q == ST_MC_BUSY) && !cnt_zero);

    mc_latency_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (MC_LOAD),
        .dec      (cnt_dec),
        .cnt      (mc_cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl        = '0;
        done_c      = 1'b0;
        br_honoured = 1'b0;
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        if (mem_wait) begin
            // whole front end and EX hold; MEM result is not ready, bubble WB
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if ((state_q == ST_RUN) && ex_branch_taken) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            br_honoured      = 1'b1;
        end else if (mc_hold) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end

        if (!mem_wait) begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_mc_start) begin
                        state_d  = ST_MC_BUSY;
                        cnt_load = 1'b1;
                    end
                end
                ST_MC_BUSY: begin
                    if (cnt_zero) begin
                        done_c  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // All outputs read as zero for as long as reset is held
    assign pc_stall     = ctrl.pc_stall     & ~rst;
    assign if_id_stall  = ctrl.if_id_stall  & ~rst;
    assign id_ex_stall  = ctrl.id_ex_stall  & ~rst;
    assign ex_mem_stall = ctrl.ex_mem_stall & ~rst;
    assign mem_wb_stall = ctrl.mem_wb_stall & ~rst;
    assign if_id_flush  = ctrl.if_id_flush  & ~rst;
    assign id_ex_flush  = ctrl.id_ex_flush  & ~rst;
    assign ex_mem_flush = ctrl.ex_mem_flush & ~rst;
    assign mem_wb_flush = ctrl.mem_wb_flush & ~rst;
    assign mc_done      = done_c            & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (ctrl.pc_stall) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (br_honoured) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end
`else
    logic unused_br;
    assign unused_br = br_honoured;
`endif

endmodule
